// File: rtl/cgra_isa_pkg.sv
// Opcode and error-code definitions shared by the decode/dispatch slice.
package cgra_isa_pkg;

   localparam logic [2:0] OP_D0   = 3'b000;
   localparam logic [2:0] OP_D1   = 3'b001;
   localparam logic [2:0] OP_W    = 3'b010;
   localparam logic [2:0] OP_TPFX = 3'b011;
   localparam logic [2:0] OP_IPFX = 3'b100;
   localparam logic [2:0] OP_FRAG = 3'b101;

   typedef enum logic [2:0] {
      ERR_NONE       = 3'd0,
      ERR_DUP_PREFIX = 3'd1,
      ERR_OVERFLOW   = 3'd2,
      ERR_NO_FRAG    = 3'd3,
      ERR_NESTED     = 3'd4,
      ERR_ORPHAN     = 3'd5,
      ERR_BAD_OP     = 3'd6
   } err_code_e;

   // Widen the 6-bit low immediate when no I-prefix supplies the upper bits.
   function automatic logic [31:0] ext_immlo(input logic [5:0] lo, input logic sext);
      return sext ? {{26{lo[5]}}, lo} : {26'd0, lo};
   endfunction

endpackage

// File: rtl/prefix_merger_pipe_reg.sv
// Single output register with valid/ready hold; reloads over a same-cycle pop.
module pipe_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic         i_ready,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   logic         r_valid;
   logic [W-1:0] r_data;

   // Load wins over pop so back-to-back traffic keeps valid high.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/prefix_merger.sv
// Folds T/I prefix words into the following D/W word, tracks fragment
// boundaries and emits one registered merged instruction per D/W word.
module prefix_merger
   import cgra_isa_pkg::*;
#(
   parameter int NALLOC_W   = 6,
   parameter int TA_W       = 6,
   parameter bit SEXT_IMMLO = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            in_op,
   input  logic [3:0]            in_funct,
   input  logic                  in_immab,
   input  logic [5:0]            in_immlo,
   input  logic [25:0]           in_immhi,
   input  logic [4*TA_W-1:0]     in_ta,
   input  logic [7:0]            in_tt,
   input  logic [9:0]            in_offset,
   input  logic [NALLOC_W-1:0]   in_nalloc,
   input  logic                  in_endF,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [2:0]            out_op,
   output logic [3:0]            out_funct,
   output logic                  out_immab,
   output logic [9:0]            out_offset,
   output logic [31:0]           out_imm,
   output logic [4*TA_W-1:0]     out_ta,
   output logic [7:0]            out_tt,
   output logic                  out_has_t,
   output logic [NALLOC_W-1:0]   out_seq,
   output logic                  frag_active,
   output logic                  frag_done,
   output logic [NALLOC_W-1:0]   frag_count,
   output logic                  err,
   output logic [2:0]            err_code
);

   localparam int OW = 3 + 4 + 1 + 10 + 32 + 4*TA_W + 8 + 1 + NALLOC_W;

   logic                r_t_pend, r_i_pend;
   logic [2*TA_W-1:0]   r_t_ta;
   logic [3:0]          r_t_tt;
   logic [25:0]         r_immhi;
   logic                r_frag_active, r_frag_done, r_err;
   logic [NALLOC_W-1:0] r_nalloc, r_cnt, r_frag_count;
   err_code_e           r_err_code;

   logic                w_out_valid, w_acc, w_is_dw, w_emit;
   logic [31:0]         w_imm;
   logic [2*TA_W-1:0]   w_ta_hi;
   logic [3:0]          w_tt_hi;
   logic [OW-1:0]       w_d, w_q;
   err_code_e           w_err;

   assign in_ready = !w_out_valid || out_ready;
   assign w_acc    = in_valid && in_ready;
   assign w_is_dw  = (in_op == OP_D0) || (in_op == OP_D1) || (in_op == OP_W);
   assign w_emit   = w_acc && w_is_dw && r_frag_active && (r_cnt != r_nalloc);

   assign w_imm   = r_i_pend ? {r_immhi, in_immlo} : ext_immlo(in_immlo, SEXT_IMMLO);
   assign w_ta_hi = r_t_pend ? r_t_ta : '0;
   assign w_tt_hi = r_t_pend ? r_t_tt : 4'd0;
   assign w_d     = {in_op, in_funct, in_immab, in_offset, w_imm,
                     w_ta_hi, in_ta[2*TA_W-1:0], w_tt_hi, in_tt[3:0], r_t_pend, r_cnt};

   // Classify the accepted word; a marker's own fault outranks ORPHAN.
   always_comb begin
      w_err = ERR_NONE;
      if (w_acc) begin
         case (in_op)
            OP_TPFX: if (r_t_pend) w_err = ERR_DUP_PREFIX;
            OP_IPFX: if (r_i_pend) w_err = ERR_DUP_PREFIX;
            OP_D0, OP_D1, OP_W: begin
               if (!r_frag_active)         w_err = ERR_NO_FRAG;
               else if (r_cnt == r_nalloc) w_err = ERR_OVERFLOW;
            end
            OP_FRAG: begin
               if (!in_endF && r_frag_active)       w_err = ERR_NESTED;
               else if (in_endF && !r_frag_active)  w_err = ERR_NO_FRAG;
               else if (r_t_pend || r_i_pend)       w_err = ERR_ORPHAN;
            end
            default: w_err = ERR_BAD_OP;
         endcase
      end
   end

   // Prefix, fragment and sticky-error state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_t_pend      <= 1'b0;
         r_i_pend      <= 1'b0;
         r_t_ta        <= '0;
         r_t_tt        <= 4'd0;
         r_immhi       <= 26'd0;
         r_frag_active <= 1'b0;
         r_frag_done   <= 1'b0;
         r_frag_count  <= '0;
         r_nalloc      <= '0;
         r_cnt         <= '0;
         r_err         <= 1'b0;
         r_err_code    <= ERR_NONE;
      end else begin
         r_frag_done <= 1'b0;
         if ((w_err != ERR_NONE) && !r_err) begin
            r_err      <= 1'b1;
            r_err_code <= w_err;
         end
         if (w_acc) begin
            case (in_op)
               OP_TPFX: begin
                  r_t_pend <= 1'b1;
                  r_t_ta   <= in_ta[4*TA_W-1:2*TA_W];
                  r_t_tt   <= in_tt[7:4];
               end
               OP_IPFX: begin
                  r_i_pend <= 1'b1;
                  r_immhi  <= in_immhi;
               end
               OP_D0, OP_D1, OP_W: begin
                  r_t_pend <= 1'b0;
                  r_i_pend <= 1'b0;
                  if (w_emit) r_cnt <= r_cnt + 1'b1;
               end
               OP_FRAG: begin
                  r_t_pend <= 1'b0;
                  r_i_pend <= 1'b0;
                  if (!in_endF) begin
                     r_frag_active <= 1'b1;
                     r_nalloc      <= in_nalloc;
                     r_cnt         <= '0;
                  end else if (r_frag_active) begin
                     r_frag_active <= 1'b0;
                     r_frag_done   <= 1'b1;
                     r_frag_count  <= r_cnt;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   pipe_reg #(.W(OW)) u_out (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_emit),
      .i_ready (out_ready),
      .i_data  (w_d),
      .o_valid (w_out_valid),
      .o_data  (w_q)
   );

   assign out_valid = w_out_valid;
   assign {out_op, out_funct, out_immab, out_offset, out_imm, out_ta, out_tt,
           out_has_t, out_seq} = w_q;

   assign frag_active = r_frag_active;
   assign frag_done   = r_frag_done;
   assign frag_count  = r_frag_count;
   assign err         = r_err;
   assign err_code    = r_err_code;

endmodule

// File: tb/tb_prefix_merger.sv
// Random and directed stimulus for prefix_merger against a word-level model.
module tb_prefix_merger;

   typedef struct packed {
      logic [2:0]  op;
      logic [3:0]  funct;
      logic        immab;
      logic [5:0]  immlo;
      logic [25:0] immhi;
      logic [23:0] ta;
      logic [7:0]  tt;
      logic [9:0]  offset;
      logic [5:0]  nalloc;
      logic        endF;
   } word_t;

   typedef struct packed {
      logic [2:0]  op;
      logic [3:0]  funct;
      logic        immab;
      logic [9:0]  offset;
      logic [31:0] imm;
      logic [23:0] ta;
      logic [7:0]  tt;
      logic        has_t;
      logic [5:0]  seq;
   } out_t;

   logic clk = 1'b0, rst = 1'b0;
   logic in_valid = 1'b0, in_ready, in_immab = 1'b0, in_endF = 1'b0;
   logic [2:0]  in_op = 3'd0;
   logic [3:0]  in_funct = 4'd0;
   logic [5:0]  in_immlo = 6'd0, in_nalloc = 6'd0;
   logic [25:0] in_immhi = 26'd0;
   logic [23:0] in_ta = 24'd0;
   logic [7:0]  in_tt = 8'd0;
   logic [9:0]  in_offset = 10'd0;
   logic out_valid, out_ready = 1'b0, out_immab, out_has_t;
   logic [2:0]  out_op, err_code;
   logic [3:0]  out_funct;
   logic [9:0]  out_offset;
   logic [31:0] out_imm;
   logic [23:0] out_ta;
   logic [7:0]  out_tt;
   logic [5:0]  out_seq, frag_count;
   logic frag_active, frag_done, err;

   prefix_merger #(.NALLOC_W(6), .TA_W(6), .SEXT_IMMLO(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_funct(in_funct), .in_immab(in_immab), .in_immlo(in_immlo),
      .in_immhi(in_immhi), .in_ta(in_ta), .in_tt(in_tt), .in_offset(in_offset),
      .in_nalloc(in_nalloc), .in_endF(in_endF), .out_valid(out_valid),
      .out_ready(out_ready), .out_op(out_op), .out_funct(out_funct),
      .out_immab(out_immab), .out_offset(out_offset), .out_imm(out_imm),
      .out_ta(out_ta), .out_tt(out_tt), .out_has_t(out_has_t), .out_seq(out_seq),
      .frag_active(frag_active), .frag_done(frag_done), .frag_count(frag_count),
      .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_miss = 0;

   // reference model state, one entry per architectural concept
   bit   m_active, m_tp, m_ip, m_err, m_ov, m_fdone, m_emit;
   int   m_nalloc, m_cnt, m_fcount, m_code;
   logic [11:0] m_ta34;
   logic [3:0]  m_tt34;
   logic [25:0] m_immhi;
   out_t exp_q[$], obs_q[$];

   function automatic out_t snap();
      out_t o;
      o.op = out_op; o.funct = out_funct; o.immab = out_immab; o.offset = out_offset;
      o.imm = out_imm; o.ta = out_ta; o.tt = out_tt; o.has_t = out_has_t; o.seq = out_seq;
      return o;
   endfunction

   function automatic void flag(input int c);
      if (!m_err) begin m_err = 1; m_code = c; end
   endfunction

   // word-level rules: what one accepted word does to the stream
   function automatic void model(input word_t w);
      out_t e;
      case (int'(w.op))
         3: begin if (m_tp) flag(1); m_tp = 1; m_ta34 = w.ta[23:12]; m_tt34 = w.tt[7:4]; end
         4: begin if (m_ip) flag(1); m_ip = 1; m_immhi = w.immhi; end
         0, 1, 2: begin
            if (!m_active) flag(3);
            else if (m_cnt == m_nalloc) flag(2);
            else begin
               e.op = w.op; e.funct = w.funct; e.immab = w.immab; e.offset = w.offset;
               e.imm = m_ip ? {m_immhi, w.immlo} : 32'($signed(w.immlo));
               e.ta = {(m_tp ? m_ta34 : 12'd0), w.ta[11:0]};
               e.tt = {(m_tp ? m_tt34 : 4'd0), w.tt[3:0]};
               e.has_t = m_tp; e.seq = 6'(m_cnt);
               exp_q.push_back(e);
               m_cnt++; m_emit = 1;
            end
            m_tp = 0; m_ip = 0;
         end
         5: begin
            if (!w.endF) begin
               if (m_active) flag(4);
               m_active = 1; m_nalloc = int'(w.nalloc); m_cnt = 0;
            end else if (!m_active) flag(3);
            else begin m_active = 0; m_fdone = 1; m_fcount = m_cnt; end
            if (m_tp || m_ip) flag(5);
            m_tp = 0; m_ip = 0;
         end
         default: flag(6);
      endcase
   endfunction

   // one clock: drive at negedge, record pops, advance model at posedge
   task automatic cycle(input word_t w, input logic v, input logic ordy);
      bit acc, pop;
      @(negedge clk);
      in_valid = v; in_op = w.op; in_funct = w.funct; in_immab = w.immab;
      in_immlo = w.immlo; in_immhi = w.immhi; in_ta = w.ta; in_tt = w.tt;
      in_offset = w.offset; in_nalloc = w.nalloc; in_endF = w.endF; out_ready = ordy;
      #1;
      if (out_valid && out_ready) obs_q.push_back(snap());
      pop = m_ov && ordy;
      acc = v && (!m_ov || ordy);
      @(posedge clk);
      m_fdone = 0; m_emit = 0;
      if (acc) model(w);
      if (m_emit) m_ov = 1; else if (pop) m_ov = 0;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; in_valid = 0; out_ready = 0;
      @(posedge clk); #1;
      rst = 0;
      m_active = 0; m_tp = 0; m_ip = 0; m_err = 0; m_ov = 0; m_fdone = 0;
      m_nalloc = 0; m_cnt = 0; m_fcount = 0; m_code = 0;
      exp_q.delete(); obs_q.delete();
   endtask

   function automatic word_t w_base(input logic [2:0] op);
      word_t w;
      w = '0; w.op = op; w.funct = 4'h3; w.immab = 1'b1; w.offset = 10'h12;
      w.ta = 24'h000ABC; w.tt = 8'h05;
      return w;
   endfunction
   function automatic word_t w_start(input int n);
      word_t w = w_base(3'b101); w.nalloc = 6'(n); return w;
   endfunction
   function automatic word_t w_end();
      word_t w = w_base(3'b101); w.endF = 1'b1; return w;
   endfunction
   function automatic word_t w_d(input logic [5:0] lo);
      word_t w = w_base(3'b000); w.immlo = lo; return w;
   endfunction
   function automatic word_t w_t(input logic [5:0] a3, input logic [5:0] a4);
      word_t w = w_base(3'b011); w.ta = {a4, a3, 12'h777}; w.tt = 8'hC3; return w;
   endfunction
   function automatic word_t w_i(input logic [25:0] hi);
      word_t w = w_base(3'b100); w.immhi = hi; return w;
   endfunction

   function automatic word_t w_rand();
      word_t w;
      int r = $urandom_range(0, 99);
      w.funct = 4'($urandom); w.immab = 1'($urandom); w.immlo = 6'($urandom);
      w.immhi = 26'($urandom); w.ta = 24'($urandom); w.tt = 8'($urandom);
      w.offset = 10'($urandom); w.nalloc = 6'($urandom_range(0, 6));
      w.endF = ($urandom_range(0, 2) != 0);
      if (r < 50)      w.op = 3'($urandom_range(0, 2));
      else if (r < 62) w.op = 3'b011;
      else if (r < 74) w.op = 3'b100;
      else if (r < 96) w.op = 3'b101;
      else             w.op = 3'($urandom_range(6, 7));
      return w;
   endfunction

   task automatic test_reset();
      do_reset();
      n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_vec++; if ({frag_active, frag_done, err} !== 3'b000) begin n_miss++; $display("FAIL reset_flags got %b want 000", {frag_active, frag_done, err}); end
      n_vec++; if (err_code !== 3'd0 || frag_count !== 6'd0) begin n_miss++; $display("FAIL reset_codes got %0d/%0d want 0/0", err_code, frag_count); end
      n_vec++; if (out_imm !== 32'd0) begin n_miss++; $display("FAIL reset_out_imm got %h want 0", out_imm); end
   endtask

   task automatic test_imm_merge();
      word_t z = '0;
      do_reset();
      cycle(w_start(2), 1, 1); cycle(w_i(26'h1), 1, 1); cycle(w_d(6'h05), 1, 1);
      cycle(w_d(6'h3F), 1, 1); cycle(w_end(), 1, 1); cycle(z, 0, 1);
      n_vec++; if (obs_q.size() !== 2) begin n_miss++; $display("FAIL imm_count got %0d want 2", obs_q.size()); end
      if (obs_q.size() == 2 && exp_q.size() == 2) begin
         n_vec++; if (obs_q[0].imm !== 32'h00000045) begin n_miss++; $display("FAIL imm_prefixed got %h want 00000045", obs_q[0].imm); end
         n_vec++; if ({obs_q[0].seq, obs_q[0].has_t} !== 7'b000000_0) begin n_miss++; $display("FAIL imm_seq0 got %h want 0", {obs_q[0].seq, obs_q[0].has_t}); end
         n_vec++; if (obs_q[1].imm !== 32'hFFFFFFFF) begin n_miss++; $display("FAIL imm_sext got %h want ffffffff", obs_q[1].imm); end
         n_vec++; if (obs_q[1].ta[23:12] !== 12'd0) begin n_miss++; $display("FAIL imm_ta_hi got %h want 0", obs_q[1].ta[23:12]); end
         for (int i = 0; i < 2; i++) begin
            n_vec++; if (obs_q[i] !== exp_q[i]) begin n_miss++; $display("FAIL imm_pkt%0d got %h want %h", i, obs_q[i], exp_q[i]); end
         end
      end
      n_vec++; if (frag_count !== 6'd2 || err !== 1'b0) begin n_miss++; $display("FAIL imm_frag got cnt %0d err %b want 2 0", frag_count, err); end
   endtask

   task automatic test_stall();
      word_t z = '0;
      do_reset();
      cycle(w_start(4), 1, 1); cycle(w_t(6'd5, 6'd9), 1, 1); cycle(w_d(6'h01), 1, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(w_d(6'h02), 1, 0);
         n_vec++; if ({out_valid, in_ready} !== 2'b10) begin n_miss++; $display("FAIL stall_hs%0d got %b want 10", i, {out_valid, in_ready}); end
         n_vec++; if (out_ta[23:12] !== {6'd9, 6'd5}) begin n_miss++; $display("FAIL stall_ta%0d got %h want 245", i, out_ta[23:12]); end
      end
      cycle(z, 0, 1); cycle(z, 0, 0);
      n_vec++; if (out_valid !== 1'b0 || obs_q.size() !== 1) begin n_miss++; $display("FAIL stall_xfer got v=%b n=%0d want 0 1", out_valid, obs_q.size()); end
      if (obs_q.size() == 1 && exp_q.size() == 1) begin
         n_vec++; if (obs_q[0] !== exp_q[0] || !obs_q[0].has_t) begin n_miss++; $display("FAIL stall_pkt got %h want %h", obs_q[0], exp_q[0]); end
      end
   endtask

   task automatic test_overflow();
      word_t z = '0;
      do_reset();
      cycle(w_start(1), 1, 1); cycle(w_d(6'h01), 1, 1); cycle(w_d(6'h02), 1, 1);
      cycle(z, 0, 1); cycle(z, 0, 1);
      n_vec++; if (obs_q.size() !== 1) begin n_miss++; $display("FAIL ovf_count got %0d want 1", obs_q.size()); end
      n_vec++; if (err !== 1'b1 || err_code !== 3'd2) begin n_miss++; $display("FAIL ovf_err got %b/%0d want 1/2", err, err_code); end
   endtask

   task automatic test_orphan();
      word_t z = '0;
      do_reset();
      cycle(w_start(3), 1, 1); cycle(w_d(6'h01), 1, 1); cycle(w_t(6'd1, 6'd2), 1, 1);
      cycle(w_end(), 1, 1);
      n_vec++; if (frag_done !== 1'b1 || frag_count !== 6'd1) begin n_miss++; $display("FAIL orph_done got %b/%0d want 1/1", frag_done, frag_count); end
      n_vec++; if (err_code !== 3'd5) begin n_miss++; $display("FAIL orph_code got %0d want 5", err_code); end
      cycle(z, 0, 1);
      n_vec++; if (frag_done !== 1'b0 || frag_active !== 1'b0) begin n_miss++; $display("FAIL orph_pulse got %b/%b want 0/0", frag_done, frag_active); end
   endtask

   task automatic test_rst_mid();
      do_reset();
      cycle(w_start(3), 1, 1); cycle(w_t(6'd1, 6'd2), 1, 1); cycle(w_t(6'd3, 6'd4), 1, 1);
      cycle(w_d(6'h07), 1, 0);
      n_vec++; if (out_valid !== 1'b1 || err !== 1'b1) begin n_miss++; $display("FAIL rstm_pre got %b/%b want 1/1", out_valid, err); end
      do_reset();
      n_vec++; if ({out_valid, frag_active, err} !== 3'b000 || err_code !== 3'd0) begin n_miss++; $display("FAIL rstm_post got %b code %0d want 000 0", {out_valid, frag_active, err}, err_code); end
      cycle(w_d(6'h07), 1, 1);
      n_vec++; if (err_code !== 3'd3 || out_valid !== 1'b0) begin n_miss++; $display("FAIL rstm_nofrag got %0d/%b want 3/0", err_code, out_valid); end
   endtask

   task automatic test_random();
      word_t z = '0;
      int shown = 0;
      for (int seg = 0; seg < 8; seg++) begin
         do_reset();
         for (int c = 0; c < 200; c++) begin
            bit ordy = ($urandom_range(0, 3) != 0);
            cycle(w_rand(), 1'($urandom_range(0, 4) != 0), ordy);
            n_vec++;
            if (out_valid !== m_ov || in_ready !== (!m_ov || ordy) || frag_active !== m_active ||
                frag_done !== m_fdone || frag_count !== 6'(m_fcount) || err !== m_err ||
                err_code !== 3'(m_code)) begin
               n_miss++;
               if (shown++ < 10)
                  $display("FAIL rand_state seg%0d cyc%0d got v%b r%b a%b d%b c%0d e%b k%0d want v%b r%b a%b d%b c%0d e%b k%0d",
                           seg, c, out_valid, in_ready, frag_active, frag_done, frag_count, err, err_code,
                           m_ov, !m_ov || ordy, m_active, m_fdone, m_fcount, m_err, m_code);
            end
         end
         cycle(z, 0, 1); cycle(z, 0, 1);
         n_vec++; if (obs_q.size() !== exp_q.size()) begin n_miss++; $display("FAIL rand_count seg%0d got %0d want %0d", seg, obs_q.size(), exp_q.size()); end
         for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
               n_miss++;
               if (shown++ < 10) $display("FAIL rand_pkt seg%0d #%0d got %h want %h", seg, i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_imm_merge();
      test_stall();
      test_overflow();
      test_orphan();
      test_rst_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

endmodule
